data_mem_access: RTL

//  MEM-stage load/store unit between the EX/MEM pipeline register and a variable-latency data memory.

---
 rtl/data_mem_access.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_access.sv
// MEM-stage load/store unit: turns one pipeline memory op into a word-aligned,
// byte-enabled request to a variable-latency data memory. It stalls the pipeline
// until the access completes and flags misaligned accesses and memory timeouts.
module data_mem_access #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReqValid,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic [31:0] AddrM,
    input  logic [31:0] StoreDataM,
    output logic        DmReqValid,
    input  logic        DmReqReady,
    output logic [31:0] DmAddr,
    output logic [3:0]  DmWe,
    output logic [31:0] DmWData,
    input  logic        DmRspValid,
    input  logic [31:0] DmRData,
    output logic        StallM,
    output logic [31:0] LoadDataW,
    output logic [1:0]  LoadedBytesSelect,
    output logic        LoadDoneW,
    output logic        MisalignExc,
    output logic        BusErr
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;
    logic          misaligned;
    logic          accept;
    logic [31:0]   addr_q;
    logic [3:0]    we_q;
    logic [31:0]   wdata_q;
    logic          is_store_q;
    logic [3:0]    we_calc;
    logic [31:0]   wdata_calc;

    // Decode alignment of the incoming op and whether it is taken this cycle
    always_comb begin
        misaligned = 1'b0;
        if (MemSizeM == 2'b01) begin
            misaligned = AddrM[0];
        end else if (MemSizeM[1]) begin
            misaligned = (AddrM[1:0] != 2'b00);
        end
        accept      = (state == IDLE) && MemReqValid && !misaligned;
        cnt_inc     = cnt + CW'(1);
        timeout_hit = (cnt_inc == CW'(TIMEOUT_CYCLES));
    end

    // Byte lane enables and replicated store data for the incoming op
    always_comb begin
        we_calc    = 4'b1111;
        wdata_calc = StoreDataM;
        case (MemSizeM)
            2'b00: begin
                we_calc    = 4'b0001 << AddrM[1:0];
                wdata_calc = {4{StoreDataM[7:0]}};
            end
            2'b01: begin
                we_calc    = AddrM[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{StoreDataM[15:0]}};
            end
            default: begin
                we_calc    = 4'b1111;
                wdata_calc = StoreDataM;
            end
        endcase
    end

    // Next-state logic plus the state-decoded request and stall outputs
    always_comb begin
        state_next = state;
        StallM     = 1'b0;
        DmReqValid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    StallM     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                DmReqValid = 1'b1;
                StallM     = 1'b1;
                if (DmReqReady) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (DmRspValid || timeout_hit) begin
                    state_next = IDLE;
                end else begin
                    StallM = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the accepted op so the request stays stable while memory is busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            we_q       <= '0;
            wdata_q    <= '0;
            is_store_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= AddrM;
            we_q       <= MemWriteM ? we_calc : 4'b0000;
            wdata_q    <= wdata_calc;
            is_store_q <= MemWriteM;
        end
    end

    // Cycles spent waiting for a response, restarted at the ready handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((state == REQ) && DmReqReady) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt_inc;
        end
    end

    // Completed-load data and the single-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LoadDataW         <= '0;
            LoadedBytesSelect <= '0;
            LoadDoneW         <= 1'b0;
            MisalignExc       <= 1'b0;
            BusErr            <= 1'b0;
        end else begin
            LoadDoneW   <= 1'b0;
            MisalignExc <= (state == IDLE) && MemReqValid && misaligned;
            BusErr      <= (state == WAIT) && !DmRspValid && timeout_hit;
            if ((state == WAIT) && DmRspValid && !is_store_q) begin
                LoadDataW         <= DmRData;
                LoadedBytesSelect <= addr_q[1:0];
                LoadDoneW         <= 1'b1;
            end
        end
    end

    assign DmAddr  = {addr_q[31:2], 2'b00};
    assign DmWe    = we_q;
    assign DmWData = wdata_q;

endmodule
